// File: rtl/pxtiming_ctl_pkg.sv
// Shared constants for the pixel-timing mode-set sequencer: attribute field
// layout, sequencer state encodings and shadow word addresses.
package pxtiming_ctl_pkg;
  localparam int ATTRMAX = 208;

  localparam int VACT_LO  = 0;
  localparam int HACT_LO  = 16;
  localparam int VTOT_LO  = 32;
  localparam int HTOT_LO  = 48;
  localparam int VSYNC_LO = 64;
  localparam int HSYNC_LO = 80;
  localparam int VDATA_LO = 96;
  localparam int HDATA_LO = 112;
  localparam int MISC_LO  = 128;
  localparam int MVID_LO  = 144;
  localparam int NVID_LO  = 168;
  localparam int SCLK_LO  = 192;

  localparam logic [2:0] PXC_OFF   = 3'd0;
  localparam logic [2:0] PXC_LOAD  = 3'd1;
  localparam logic [2:0] PXC_START = 3'd2;
  localparam logic [2:0] PXC_RUN   = 3'd3;
  localparam logic [2:0] PXC_WAITV = 3'd4;

  localparam logic [2:0] SH_ACT  = 3'd0;
  localparam logic [2:0] SH_TOT  = 3'd1;
  localparam logic [2:0] SH_SYNC = 3'd2;
  localparam logic [2:0] SH_DATA = 3'd3;
  localparam logic [2:0] SH_MISC = 3'd4;
  localparam logic [2:0] SH_MVID = 3'd5;
  localparam logic [2:0] SH_NVID = 3'd6;
  localparam logic [2:0] SH_SCLK = 3'd7;

  typedef logic [ATTRMAX:0] attr_t;
endpackage

// File: rtl/pxtiming_ctl_attrcheck.sv
// Combinational sanity check of a shadow timing set before it may be applied.
module pxtiming_ctl_attrcheck (
  input  logic [15:0] hact,
  input  logic [15:0] htot,
  input  logic [15:0] vact,
  input  logic [15:0] vtot,
  input  logic [15:0] hsync,
  input  logic [15:0] vsync,
  input  logic [16:0] sclkinc,
  output logic        valid
);
  assign valid = (hact < htot) && (vact <= vtot) && (hsync < htot) &&
                 (vsync <= vtot) && (sclkinc != 17'd0);
endmodule

// File: rtl/pxtiming_ctl.sv
// Mode-set sequencer: shadows the timing attributes, validates on commit and
// swaps them into the timing generator only while it is held in reset.
module pxtiming_ctl
  import pxtiming_ctl_pkg::*;
#(
  parameter int          RSTCYC  = 4,
  parameter logic [31:0] TIMEOUT = 32'd16777215
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           regwe,
  input  logic [2:0]     regaddr,
  input  logic [31:0]    regdata,
  input  logic           commit,
  input  logic           dpvstart,
  output logic [ATTRMAX:0] attr,
  output logic           pxreset,
  output logic           running,
  output logic           busy,
  output logic           err
);
  localparam logic [31:0] RST_LAST = 32'(RSTCYC - 1);
  localparam logic [31:0] TO_LAST  = TIMEOUT - 32'd1;

  attr_t       shadow;
  logic [2:0]  state, nxt;
  logic [31:0] cnt;
  logic        pending, nxt_pend, nxt_err;
  logic        load_attr, cnt_clr, valid, cmt_ok;

  pxtiming_ctl_attrcheck u_attrcheck (
    .hact   (shadow[HACT_LO +: 16]),
    .htot   (shadow[HTOT_LO +: 16]),
    .vact   (shadow[VACT_LO +: 16]),
    .vtot   (shadow[VTOT_LO +: 16]),
    .hsync  (shadow[HSYNC_LO +: 16]),
    .vsync  (shadow[VSYNC_LO +: 16]),
    .sclkinc(shadow[SCLK_LO +: 17]),
    .valid  (valid)
  );

  assign cmt_ok = commit & valid;

  always_comb begin
    nxt       = state;
    nxt_pend  = pending;
    nxt_err   = err;
    load_attr = 1'b0;
    cnt_clr   = 1'b0;
    if (!enable) begin
      nxt      = PXC_OFF;
      nxt_pend = 1'b0;
    end else begin
      if (commit) nxt_err = ~valid;
      case (state)
        PXC_OFF: if (cmt_ok) begin
          nxt = PXC_LOAD; load_attr = 1'b1; cnt_clr = 1'b1;
        end
        PXC_LOAD: begin
          if (cmt_ok) nxt_pend = 1'b1;
          if (cnt == RST_LAST) begin
            nxt = PXC_START; cnt_clr = 1'b1;
          end
        end
        PXC_START: begin
          if (cmt_ok) nxt_pend = 1'b1;
          if (dpvstart) nxt = PXC_RUN;
          else if (cnt == TO_LAST) begin
            nxt = PXC_OFF; nxt_err = 1'b1; nxt_pend = 1'b0;
          end
        end
        // A dpvstart coinciding with the commit is left for the old mode.
        PXC_RUN: if (cmt_ok || pending) begin
          nxt = PXC_WAITV; nxt_pend = 1'b0;
        end
        PXC_WAITV: if (dpvstart) begin
          nxt = PXC_LOAD; load_attr = 1'b1; cnt_clr = 1'b1;
        end
        default: nxt = PXC_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= PXC_OFF;
      pending <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      attr    <= '0;
      pxreset <= 1'b1;
      running <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nxt;
      pending <= nxt_pend;
      err     <= nxt_err;
      cnt     <= cnt_clr ? 32'd0 : cnt + 32'd1;
      if (load_attr) attr <= shadow;
      pxreset <= (nxt == PXC_OFF) || (nxt == PXC_LOAD);
      running <= (nxt == PXC_RUN) || (nxt == PXC_WAITV);
      busy    <= (nxt == PXC_LOAD) || (nxt == PXC_START) || (nxt == PXC_WAITV);
    end
  end

  // Shadow updates land on the same edge a commit is sampled, so validation
  // and the LOAD snapshot always see the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
    end else if (regwe) begin
      case (regaddr)
        SH_ACT:  shadow[VACT_LO  +: 32] <= regdata;
        SH_TOT:  shadow[VTOT_LO  +: 32] <= regdata;
        SH_SYNC: shadow[VSYNC_LO +: 32] <= regdata;
        SH_DATA: shadow[VDATA_LO +: 32] <= regdata;
        SH_MISC: shadow[MISC_LO  +: 16] <= regdata[15:0];
        SH_MVID: shadow[MVID_LO  +: 24] <= regdata[23:0];
        SH_NVID: shadow[NVID_LO  +: 24] <= regdata[23:0];
        default: shadow[SCLK_LO  +: 17] <= regdata[16:0];
      endcase
    end
  end
endmodule

// File: tb/tb_pxtiming_ctl.sv
// Randomised scoreboard bench for pxtiming_ctl against a field-level model.
module tb_pxtiming_ctl;
  localparam int RSTCYC  = 4;
  localparam int TIMEOUT = 100;

  logic         clk = 0, reset = 1, enable = 0, regwe = 0, commit = 0, dpvstart = 0;
  logic [2:0]   regaddr = 0;
  logic [31:0]  regdata = 0;
  logic [208:0] d_attr;
  logic         d_pxreset, d_running, d_busy, d_err;

  pxtiming_ctl #(.RSTCYC(RSTCYC), .TIMEOUT(32'(TIMEOUT))) dut (
    .clk(clk), .reset(reset), .enable(enable), .regwe(regwe), .regaddr(regaddr),
    .regdata(regdata), .commit(commit), .dpvstart(dpvstart), .attr(d_attr),
    .pxreset(d_pxreset), .running(d_running), .busy(d_busy), .err(d_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hact, vact, htot, vtot, hsync, vsync, hdata, vdata, misc;
    logic [23:0] mvid, nvid;
    logic [16:0] sclk;
  } fields_t;

  typedef struct {
    logic [208:0] attr;
    logic         pxr, run, busy, err;
  } exp_t;

  typedef enum {M_OFF, M_LOAD, M_START, M_RUN, M_WAITV} phase_t;

  fields_t m_sh, m_act;
  phase_t  m_ph;
  int      m_left, m_waited;
  bit      m_pend, m_err;
  exp_t    exp_q[$];
  exp_t    mon_e;
  int      total = 0, bad = 0;

  function automatic logic [208:0] pack(fields_t f);
    logic [208:0] v;
    v = '0;
    v[15:0] = f.vact;    v[31:16] = f.hact;   v[47:32] = f.vtot;    v[63:48] = f.htot;
    v[79:64] = f.vsync;  v[95:80] = f.hsync;  v[111:96] = f.vdata;  v[127:112] = f.hdata;
    v[143:128] = f.misc; v[167:144] = f.mvid; v[191:168] = f.nvid;  v[208:192] = f.sclk;
    return v;
  endfunction

  function automatic fields_t zero_fields();
    fields_t f;
    f = '{default: '0};
    return f;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic exp_t model_step();
    exp_t    e;
    fields_t snap;
    bit      ok;
    if (reset) begin
      m_sh = zero_fields(); m_act = zero_fields();
      m_ph = M_OFF; m_pend = 0; m_err = 0;
    end else begin
      snap = m_sh;
      ok = (snap.hact < snap.htot) && (snap.vact <= snap.vtot) &&
           (snap.hsync < snap.htot) && (snap.vsync <= snap.vtot) && (snap.sclk != 0);
      if (regwe) begin
        case (regaddr)
          3'd0: begin m_sh.hact = regdata[31:16];  m_sh.vact = regdata[15:0];  end
          3'd1: begin m_sh.htot = regdata[31:16];  m_sh.vtot = regdata[15:0];  end
          3'd2: begin m_sh.hsync = regdata[31:16]; m_sh.vsync = regdata[15:0]; end
          3'd3: begin m_sh.hdata = regdata[31:16]; m_sh.vdata = regdata[15:0]; end
          3'd4: m_sh.misc = regdata[15:0];
          3'd5: m_sh.mvid = regdata[23:0];
          3'd6: m_sh.nvid = regdata[23:0];
          default: m_sh.sclk = regdata[16:0];
        endcase
      end
      if (!enable) begin
        m_ph = M_OFF; m_pend = 0;
      end else begin
        if (commit) m_err = !ok;
        case (m_ph)
          M_OFF: if (commit && ok) begin m_ph = M_LOAD; m_act = snap; m_left = RSTCYC; end
          M_LOAD: begin
            if (commit && ok) m_pend = 1;
            m_left--;
            if (m_left == 0) begin m_ph = M_START; m_waited = 0; end
          end
          M_START: begin
            if (commit && ok) m_pend = 1;
            m_waited++;
            if (dpvstart) m_ph = M_RUN;
            else if (m_waited == TIMEOUT) begin m_ph = M_OFF; m_err = 1; m_pend = 0; end
          end
          M_RUN: if ((commit && ok) || m_pend) begin m_ph = M_WAITV; m_pend = 0; end
          default: if (dpvstart) begin m_ph = M_LOAD; m_act = snap; m_left = RSTCYC; end
        endcase
      end
    end
    e.attr = pack(m_act);
    e.pxr  = (m_ph == M_OFF) || (m_ph == M_LOAD);
    e.run  = (m_ph == M_RUN) || (m_ph == M_WAITV);
    e.busy = (m_ph == M_LOAD) || (m_ph == M_START) || (m_ph == M_WAITV);
    e.err  = m_err;
    return e;
  endfunction

  task automatic chk(input string name, input logic [208:0] act, input logic [208:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("attr",    d_attr,           mon_e.attr);
      chk("pxreset", 209'(d_pxreset),  209'(mon_e.pxr));
      chk("running", 209'(d_running),  209'(mon_e.run));
      chk("busy",    209'(d_busy),     209'(mon_e.busy));
      chk("err",     209'(d_err),      209'(mon_e.err));
    end
  end

  task automatic tick();
    exp_t e;
    e = model_step();
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    regwe = 0; commit = 0; dpvstart = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    regwe = 1; regaddr = a; regdata = d; tick();
  endtask

  task automatic do_commit();
    commit = 1; tick();
  endtask

  task automatic vstart();
    dpvstart = 1; tick();
  endtask

  initial begin
    int lowcnt;
    reset = 1;
    idle(2);
    reset = 0; enable = 1;
    // bring-up of 1920x1080
    wr(3'd0, {16'd1920, 16'd1080});
    wr(3'd1, {16'd2200, 16'd1124});
    wr(3'd7, 32'h0000_8000);
    do_commit();
    idle(6);
    vstart();
    idle(3);
    // mode change from RUN waits for the next frame start
    wr(3'd1, {16'd2000, 16'd1124});
    do_commit();
    idle(5);
    vstart();
    idle(6);
    vstart();
    idle(2);
    // invalid commit, then a valid one
    wr(3'd0, {16'd2200, 16'd1080});
    wr(3'd1, {16'd2200, 16'd1124});
    do_commit();
    idle(2);
    wr(3'd0, {16'd1920, 16'd1080});
    do_commit();
    idle(2);
    vstart();
    idle(6);
    vstart();
    idle(2);
    // lock timeout
    enable = 0; tick(); enable = 1;
    do_commit();
    lowcnt = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (d_pxreset === 1'b0) lowcnt++;
    end
    chk("timeout_low_cycles", 209'(lowcnt), 209'(TIMEOUT));
    chk("timeout_err", 209'(d_err), 209'(1));
    // enable drop in WAITV with coincident dpvstart
    do_commit();
    idle(5);
    vstart();
    do_commit();
    idle(1);
    enable = 0; dpvstart = 1; tick();
    enable = 1; tick();
    // reset in the middle of LOAD
    do_commit();
    idle(2);
    reset = 1; tick();
    reset = 0; tick();
    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) begin
        regwe   = 1;
        regaddr = 3'($urandom_range(0, 7));
        if (regaddr <= 3'd3) regdata = {16'($urandom_range(0, 300)), 16'($urandom_range(0, 300))};
        else if (regaddr == 3'd7) regdata = 32'($urandom_range(0, 3));
        else regdata = $urandom;
      end
      commit   = ($urandom_range(0, 19) == 0);
      dpvstart = ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 0; enable = 1;
    idle(2);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
